// File: rtl/ddr_local_pkg.sv
// Shared types and helpers for the DDR local-interface burst splitter.
// Sizes are in words; LOCAL_SIZE_W covers the 1..64 upstream burst range.
package ddr_local_pkg;

   localparam int unsigned LOCAL_SIZE_W = 7;

   typedef enum logic [1:0] {
      StIdle,
      StWr,
      StRd
   } state_e;

   function automatic logic [LOCAL_SIZE_W-1:0] min_size(
      input logic [LOCAL_SIZE_W-1:0] rem,
      input logic [LOCAL_SIZE_W-1:0] max
   );
      return (rem < max) ? rem : max;
   endfunction

endpackage

// File: rtl/ddr_local_sub_burst_gen.sv
// Tracks the current sub-burst (address, remaining words, beat within sub-burst).
// Outputs reflect the loaded values combinationally when load_i is high.
module ddr_local_sub_burst_gen
   import ddr_local_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 23,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    load_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [LOCAL_SIZE_W-1:0] size_i,
   input  logic                    beat_i,
   input  logic                    cmd_i,
   output logic [ADDR_WIDTH-1:0]   addr_o,
   output logic [LOCAL_SIZE_W-1:0] size_o,
   output logic                    first_o,
   output logic                    last_beat_o,
   output logic                    last_sub_o
);

   localparam logic [LOCAL_SIZE_W-1:0] MaxSize  = LOCAL_SIZE_W'(MAX_BURST);
   localparam logic [ADDR_WIDTH-1:0]   AddrStep = ADDR_WIDTH'(MAX_BURST);

   logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_v;
   logic [LOCAL_SIZE_W-1:0] rem_q, rem_d, rem_v;
   logic [LOCAL_SIZE_W-1:0] beat_q, beat_d, beat_v;
   logic [LOCAL_SIZE_W-1:0] size_v;
   logic                    sub_end;

   always_comb begin
      // The view is what the current beat/command uses: fresh values on load.
      if (load_i) begin
         addr_v = addr_i;
         rem_v  = (size_i == '0) ? LOCAL_SIZE_W'(1) : size_i;
         beat_v = '0;
      end else begin
         addr_v = addr_q;
         rem_v  = rem_q;
         beat_v = beat_q;
      end
      size_v  = min_size(rem_v, MaxSize);
      sub_end = (beat_v == size_v - LOCAL_SIZE_W'(1));

      addr_d = addr_v;
      rem_d  = rem_v;
      beat_d = beat_v;
      if (beat_i && !sub_end) begin
         beat_d = beat_v + LOCAL_SIZE_W'(1);
      end else if (beat_i || cmd_i) begin
         addr_d = addr_v + AddrStep;
         rem_d  = rem_v - size_v;
         beat_d = '0;
      end
   end

   assign addr_o      = addr_v;
   assign size_o      = size_v;
   assign first_o     = (beat_v == '0);
   assign last_sub_o  = (rem_v <= MaxSize);
   assign last_beat_o = sub_end && (rem_v <= MaxSize);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
         rem_q  <= '0;
         beat_q <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
         beat_q <= beat_d;
      end
   end

endmodule

// File: rtl/ddr_local_burst_splitter.sv
// Splits upstream local-interface bursts (up to 64 words) into IP sub-bursts of
// at most MAX_BURST words; read data is returned with one cycle of latency.
module ddr_local_burst_splitter
   import ddr_local_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 23,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                    local_clk_i,
   input  logic                    local_reset_n_i,
   input  logic [ADDR_WIDTH-1:0]   s_address_i,
   input  logic                    s_write_req_i,
   input  logic                    s_read_req_i,
   input  logic                    s_burstbegin_i,
   input  logic [DATA_WIDTH-1:0]   s_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] s_be_i,
   input  logic [LOCAL_SIZE_W-1:0] s_size_i,
   output logic                    s_ready_o,
   output logic [DATA_WIDTH-1:0]   s_rdata_o,
   output logic                    s_rdata_valid_o,
   output logic [ADDR_WIDTH-1:0]   m_address_o,
   output logic                    m_write_req_o,
   output logic                    m_read_req_o,
   output logic                    m_burstbegin_o,
   output logic [DATA_WIDTH-1:0]   m_wdata_o,
   output logic [DATA_WIDTH/8-1:0] m_be_o,
   output logic [LOCAL_SIZE_W-1:0] m_size_o,
   input  logic                    m_ready_i,
   input  logic [DATA_WIDTH-1:0]   m_rdata_i,
   input  logic                    m_rdata_valid_i
);

   state_e state_q, state_d;

   logic                    gen_load, gen_beat, gen_cmd;
   logic [ADDR_WIDTH-1:0]   gen_addr;
   logic [LOCAL_SIZE_W-1:0] gen_size;
   logic                    gen_first, gen_last_beat, gen_last_sub;

   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    rdata_valid_q;

   ddr_local_sub_burst_gen #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .MAX_BURST (MAX_BURST)
   ) u_gen (
      .clk_i      (local_clk_i),
      .rst_ni     (local_reset_n_i),
      .load_i     (gen_load),
      .addr_i     (s_address_i),
      .size_i     (s_size_i),
      .beat_i     (gen_beat),
      .cmd_i      (gen_cmd),
      .addr_o     (gen_addr),
      .size_o     (gen_size),
      .first_o    (gen_first),
      .last_beat_o(gen_last_beat),
      .last_sub_o (gen_last_sub)
   );

   always_comb begin
      state_d        = state_q;
      gen_load       = 1'b0;
      gen_beat       = 1'b0;
      gen_cmd        = 1'b0;
      s_ready_o      = 1'b0;
      m_write_req_o  = 1'b0;
      m_read_req_o   = 1'b0;
      m_burstbegin_o = 1'b0;
      m_address_o    = '0;
      m_size_o       = LOCAL_SIZE_W'(1);
      m_wdata_o      = '0;
      m_be_o         = '0;
      // Reset forces every output to its idle value without waiting for a clock.
      if (local_reset_n_i) begin
         unique case (state_q)
            StIdle: begin
               if (s_write_req_i) begin
                  m_write_req_o  = 1'b1;
                  m_burstbegin_o = 1'b1;
                  m_wdata_o      = s_wdata_i;
                  m_be_o         = s_be_i;
                  s_ready_o      = m_ready_i;
                  if (s_burstbegin_i) begin
                     gen_load    = 1'b1;
                     gen_beat    = m_ready_i;
                     m_address_o = gen_addr;
                     m_size_o    = gen_size;
                     if (m_ready_i && !gen_last_beat) begin
                        state_d = StWr;
                     end
                  end else begin
                     // Stray beat without burstbegin: forward as a single-word burst.
                     m_address_o = s_address_i;
                  end
               end else if (s_read_req_i) begin
                  if (s_burstbegin_i) begin
                     gen_load = 1'b1;
                     state_d  = StRd;
                  end
               end else begin
                  s_ready_o = m_ready_i;
               end
            end
            StWr: begin
               m_write_req_o  = s_write_req_i;
               m_burstbegin_o = s_write_req_i && gen_first;
               m_address_o    = gen_addr;
               m_size_o       = gen_size;
               m_wdata_o      = s_wdata_i;
               m_be_o         = s_be_i;
               s_ready_o      = m_ready_i;
               gen_beat       = s_write_req_i && m_ready_i;
               if (gen_beat && gen_last_beat) begin
                  state_d = StIdle;
               end
            end
            StRd: begin
               m_read_req_o   = 1'b1;
               m_burstbegin_o = 1'b1;
               m_address_o    = gen_addr;
               m_size_o       = gen_size;
               gen_cmd        = m_ready_i;
               if (m_ready_i && gen_last_sub) begin
                  s_ready_o = 1'b1;
                  state_d   = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
      if (!local_reset_n_i) begin
         state_q       <= StIdle;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rdata_q       <= m_rdata_i;
         rdata_valid_q <= m_rdata_valid_i;
      end
   end

   assign s_rdata_o       = rdata_q;
   assign s_rdata_valid_o = rdata_valid_q;

endmodule

// File: tb/tb_ddr_local_burst_splitter.sv
// Directed bench for the burst splitter with MAX_BURST=4, 23-bit addresses.
module tb_ddr_local_burst_splitter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [22:0] s_address = '0;
   logic        s_write_req = 1'b0;
   logic        s_read_req = 1'b0;
   logic        s_burstbegin = 1'b0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_be = '0;
   logic [6:0]  s_size = '0;
   logic        s_ready;
   logic [31:0] s_rdata;
   logic        s_rdata_valid;
   logic [22:0] m_address;
   logic        m_write_req, m_read_req, m_burstbegin;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic [6:0]  m_size;
   logic        m_ready = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        m_rdata_valid = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ddr_local_burst_splitter #(
      .ADDR_WIDTH(23),
      .DATA_WIDTH(32),
      .MAX_BURST (4)
   ) dut (
      .local_clk_i    (clk),
      .local_reset_n_i(rst_n),
      .s_address_i    (s_address),
      .s_write_req_i  (s_write_req),
      .s_read_req_i   (s_read_req),
      .s_burstbegin_i (s_burstbegin),
      .s_wdata_i      (s_wdata),
      .s_be_i         (s_be),
      .s_size_i       (s_size),
      .s_ready_o      (s_ready),
      .s_rdata_o      (s_rdata),
      .s_rdata_valid_o(s_rdata_valid),
      .m_address_o    (m_address),
      .m_write_req_o  (m_write_req),
      .m_read_req_o   (m_read_req),
      .m_burstbegin_o (m_burstbegin),
      .m_wdata_o      (m_wdata),
      .m_be_o         (m_be),
      .m_size_o       (m_size),
      .m_ready_i      (m_ready),
      .m_rdata_i      (m_rdata),
      .m_rdata_valid_i(m_rdata_valid)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_inputs();
      s_write_req = 1'b0; s_read_req = 1'b0; s_burstbegin = 1'b0;
      s_address = '0; s_size = '0; s_wdata = '0; s_be = '0;
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if ({m_write_req, m_read_req, m_burstbegin, s_rdata_valid, s_ready} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {m_write_req, m_read_req, m_burstbegin, s_rdata_valid, s_ready});
      end
      vectors++;
      if ({m_size, m_address, m_wdata, m_be, s_rdata} !== {7'd1, 23'd0, 32'd0, 4'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL reset_data: got size %0d addr %h wdata %h be %h rdata %h want 1/0/0/0/0",
                  m_size, m_address, m_wdata, m_be, s_rdata);
      end
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      logic        exp_bb;
      logic [22:0] exp_addr;
      logic [6:0]  exp_size;
      m_ready = 1'b1;
      for (int b = 0; b < 10; b++) begin
         s_write_req = 1'b1; s_burstbegin = (b == 0);
         s_address = (b == 0) ? 23'h100 : 23'h0; s_size = (b == 0) ? 7'd10 : 7'd0;
         s_wdata = 32'hD000 + 32'(b); s_be = 4'hF;
         exp_bb = (b % 4 == 0);
         exp_addr = 23'h100 + 23'((b / 4) * 4);
         exp_size = (b < 8) ? 7'd4 : 7'd2;
         #2;
         vectors++;
         if ({m_write_req, m_burstbegin, s_ready, m_wdata, m_be} !==
             {1'b1, exp_bb, 1'b1, 32'hD000 + 32'(b), 4'hF}) begin
            miscompares++;
            $display("FAIL write_beat %0d: got wr %b bb %b rdy %b data %h be %h want 1 %b 1 %h f",
                     b, m_write_req, m_burstbegin, s_ready, m_wdata, m_be, exp_bb,
                     32'hD000 + 32'(b));
         end
         if (exp_bb) begin
            vectors++;
            if ({m_address, m_size} !== {exp_addr, exp_size}) begin
               miscompares++;
               $display("FAIL write_sub beat %0d: got addr %h size %0d want %h %0d",
                        b, m_address, m_size, exp_addr, exp_size);
            end
         end
         next_cycle();
      end
      drop_inputs();
      #2;
      vectors++;
      if ({m_write_req, m_burstbegin} !== 2'b00) begin
         miscompares++;
         $display("FAIL write_end: got wr %b bb %b want 0 0", m_write_req, m_burstbegin);
      end
      next_cycle();
   endtask

   task automatic test_read_wrap();
      s_read_req = 1'b1; s_burstbegin = 1'b1; s_address = 23'h7FFFFE; s_size = 7'd8;
      m_ready = 1'b1;
      #2;
      vectors++;
      if ({s_ready, m_read_req, m_write_req} !== 3'b000) begin
         miscompares++;
         $display("FAIL read_accept: got rdy %b rd %b wr %b want 0 0 0", s_ready, m_read_req,
                  m_write_req);
      end
      next_cycle();
      #2;
      vectors++;
      if ({m_read_req, m_burstbegin, s_ready, m_address, m_size} !==
          {3'b110, 23'h7FFFFE, 7'd4}) begin
         miscompares++;
         $display("FAIL read_cmd0: got rd %b bb %b rdy %b addr %h size %0d want 1 1 0 7ffffe 4",
                  m_read_req, m_burstbegin, s_ready, m_address, m_size);
      end
      next_cycle();
      #2;
      vectors++;
      if ({m_read_req, m_burstbegin, s_ready, m_address, m_size} !==
          {3'b111, 23'h000002, 7'd4}) begin
         miscompares++;
         $display("FAIL read_cmd1: got rd %b bb %b rdy %b addr %h size %0d want 1 1 1 000002 4",
                  m_read_req, m_burstbegin, s_ready, m_address, m_size);
      end
      next_cycle();
      drop_inputs();
      #2;
      vectors++;
      if (m_read_req !== 1'b0) begin
         miscompares++;
         $display("FAIL read_end: got rd %b want 0", m_read_req);
      end
      next_cycle();
   endtask

   task automatic test_backpressure();
      logic [11:0] rdy_pat;
      logic        exp_bb;
      int          b;
      rdy_pat = 12'b1111_1111_1001;
      b = 0;
      for (int c = 0; c < 12 && b < 6; c++) begin
         m_ready = rdy_pat[c];
         s_write_req = 1'b1; s_burstbegin = (b == 0);
         s_address = (b == 0) ? 23'h200 : 23'h0; s_size = (b == 0) ? 7'd6 : 7'd0;
         s_wdata = 32'hB0 + 32'(b); s_be = 4'h3;
         exp_bb = (b == 0) || (b == 4);
         #2;
         vectors++;
         if ({m_write_req, m_burstbegin, s_ready, m_wdata} !==
             {1'b1, exp_bb, rdy_pat[c], 32'hB0 + 32'(b)}) begin
            miscompares++;
            $display("FAIL bp_beat cyc %0d: got wr %b bb %b rdy %b data %h want 1 %b %b %h",
                     c, m_write_req, m_burstbegin, s_ready, m_wdata, exp_bb, rdy_pat[c],
                     32'hB0 + 32'(b));
         end
         if (exp_bb) begin
            vectors++;
            if ({m_address, m_size} !== {(b == 0) ? 23'h200 : 23'h204, (b == 0) ? 7'd4 : 7'd2})
            begin
               miscompares++;
               $display("FAIL bp_sub cyc %0d: got addr %h size %0d", c, m_address, m_size);
            end
         end
         if (rdy_pat[c]) b++;
         next_cycle();
      end
      vectors++;
      if (b != 6) begin
         miscompares++;
         $display("FAIL bp_budget: got %0d beats want 6", b);
      end
      drop_inputs();
      m_ready = 1'b1;
      next_cycle();
   endtask

   task automatic test_read_data();
      logic        prev_v;
      logic [31:0] prev_d;
      prev_v = 1'b0; prev_d = '0;
      m_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         m_rdata_valid = (c < 12);
         m_rdata = 32'(c);
         s_write_req = (c >= 6 && c < 10); s_burstbegin = (c == 6);
         s_address = 23'h400; s_size = 7'd4; s_wdata = 32'(c); s_be = 4'hF;
         #2;
         vectors++;
         if (s_rdata_valid !== prev_v || (prev_v && s_rdata !== prev_d)) begin
            miscompares++;
            $display("FAIL rdata cyc %0d: got v %b d %h want v %b d %h", c, s_rdata_valid,
                     s_rdata, prev_v, prev_d);
         end
         if (c >= 6 && c < 10) begin
            vectors++;
            if ({m_write_req, m_burstbegin} !== {1'b1, c == 6}) begin
               miscompares++;
               $display("FAIL rdata_overlap_wr cyc %0d: got wr %b bb %b", c, m_write_req,
                        m_burstbegin);
            end
         end
         prev_v = (c < 12);
         prev_d = 32'(c);
         next_cycle();
      end
      m_rdata_valid = 1'b0;
      drop_inputs();
      next_cycle();
   endtask

   task automatic test_reset_mid_burst();
      m_ready = 1'b1;
      for (int b = 0; b < 6; b++) begin
         s_write_req = 1'b1; s_burstbegin = (b == 0);
         s_address = (b == 0) ? 23'h300 : 23'h0; s_size = (b == 0) ? 7'd16 : 7'd0;
         s_wdata = 32'hC0 + 32'(b); s_be = 4'hF;
         m_rdata_valid = (b == 4); m_rdata = 32'h55;
         #2;
         if (b == 4) begin
            vectors++;
            if ({m_burstbegin, m_address, m_size} !== {1'b1, 23'h304, 7'd4}) begin
               miscompares++;
               $display("FAIL rst_sub2: got bb %b addr %h size %0d want 1 304 4", m_burstbegin,
                        m_address, m_size);
            end
         end
         if (b < 5) next_cycle();
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({m_write_req, m_read_req, m_burstbegin, s_rdata_valid, s_ready} !== 5'b0) begin
         miscompares++;
         $display("FAIL rst_async_ctrl: got %b want 00000",
                  {m_write_req, m_read_req, m_burstbegin, s_rdata_valid, s_ready});
      end
      vectors++;
      if ({m_size, m_address, m_wdata, m_be, s_rdata} !== {7'd1, 23'd0, 32'd0, 4'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL rst_async_data: got size %0d addr %h wdata %h be %h rdata %h",
                  m_size, m_address, m_wdata, m_be, s_rdata);
      end
      drop_inputs();
      m_rdata_valid = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      s_read_req = 1'b1; s_burstbegin = 1'b1; s_address = 23'h40; s_size = 7'd1;
      next_cycle();
      #2;
      vectors++;
      if ({m_read_req, m_burstbegin, s_ready, m_address, m_size} !== {3'b111, 23'h40, 7'd1}) begin
         miscompares++;
         $display("FAIL rst_read1: got rd %b bb %b rdy %b addr %h size %0d want 1 1 1 40 1",
                  m_read_req, m_burstbegin, s_ready, m_address, m_size);
      end
      next_cycle();
      drop_inputs();
      #2;
      vectors++;
      if (m_read_req !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_read1_end: got rd %b want 0", m_read_req);
      end
      next_cycle();
   endtask

   task automatic test_corners();
      m_ready = 1'b1;
      // Size 0 read behaves as size 1.
      s_read_req = 1'b1; s_burstbegin = 1'b1; s_address = 23'h50; s_size = 7'd0;
      next_cycle();
      #2;
      vectors++;
      if ({m_read_req, s_ready, m_address, m_size} !== {2'b11, 23'h50, 7'd1}) begin
         miscompares++;
         $display("FAIL size0_read: got rd %b rdy %b addr %h size %0d want 1 1 50 1",
                  m_read_req, s_ready, m_address, m_size);
      end
      next_cycle();
      // Simultaneous write and read burstbegin: write goes first.
      s_write_req = 1'b1; s_read_req = 1'b1; s_burstbegin = 1'b1;
      s_address = 23'h10; s_size = 7'd2; s_wdata = 32'h11; s_be = 4'hF;
      #2;
      vectors++;
      if ({m_write_req, m_read_req, m_burstbegin, s_ready, m_address, m_size} !==
          {4'b1011, 23'h10, 7'd2}) begin
         miscompares++;
         $display("FAIL both_first: got wr %b rd %b bb %b rdy %b addr %h size %0d",
                  m_write_req, m_read_req, m_burstbegin, s_ready, m_address, m_size);
      end
      next_cycle();
      s_burstbegin = 1'b0; s_wdata = 32'h22;
      #2;
      vectors++;
      if ({m_write_req, m_read_req, m_burstbegin, m_wdata} !== {3'b100, 32'h22}) begin
         miscompares++;
         $display("FAIL both_beat1: got wr %b rd %b bb %b data %h want 1 0 0 22",
                  m_write_req, m_read_req, m_burstbegin, m_wdata);
      end
      next_cycle();
      s_write_req = 1'b0; s_burstbegin = 1'b1; s_address = 23'h20; s_size = 7'd1;
      #2;
      vectors++;
      if ({s_ready, m_read_req} !== 2'b00) begin
         miscompares++;
         $display("FAIL both_rd_accept: got rdy %b rd %b want 0 0", s_ready, m_read_req);
      end
      next_cycle();
      #2;
      vectors++;
      if ({m_read_req, s_ready, m_address, m_size} !== {2'b11, 23'h20, 7'd1}) begin
         miscompares++;
         $display("FAIL both_rd_cmd: got rd %b rdy %b addr %h size %0d want 1 1 20 1",
                  m_read_req, s_ready, m_address, m_size);
      end
      next_cycle();
      // Write beat without burstbegin in idle goes out as a single-word burst.
      drop_inputs();
      s_write_req = 1'b1; s_address = 23'h77; s_size = 7'd9; s_wdata = 32'h77;
      #2;
      vectors++;
      if ({m_write_req, m_burstbegin, s_ready, m_address, m_size} !== {3'b111, 23'h77, 7'd1})
      begin
         miscompares++;
         $display("FAIL stray_beat: got wr %b bb %b rdy %b addr %h size %0d want 1 1 1 77 1",
                  m_write_req, m_burstbegin, s_ready, m_address, m_size);
      end
      next_cycle();
      drop_inputs();
      #2;
      vectors++;
      if (m_write_req !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_end: got wr %b want 0", m_write_req);
      end
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_read_wrap();
      test_backpressure();
      test_read_data();
      test_reset_mid_burst();
      test_corners();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
